pgm_ddram_reader: RTL

Read responder serving the graphics-fetch port of the PGM video engine (`ddram_rd` / `ddram_addr` / `ddram_dout` / `ddram_busy` / `ddram_dout_ready`) from the MiSTer DDR3 Avalon-MM read channel. It accepts one 64-bit word request at a time and relocates the address into the graphics-ROM region of DDR. It issues the read, registers the returned word, and signals completion with a one-cycle ready pulse. It sits between the video block and the top-level DDRAM arbiter.

---
 rtl/pgm_ddram_reader_if.sv | 25 ++
 rtl/pgm_ddram_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pgm_ddram_reader_if.sv
// Fetch-port and Avalon-MM read-channel signals of the PGM graphics-ROM reader.
// The slave modport is the reader; the master modport is its environment (video engine plus DDR).
interface pgm_ddram_reader_if;
    logic        ddram_rd;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_dout;
    logic        ddram_busy;
    logic        ddram_dout_ready;
    logic        ddr_rd;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burstcnt;
    logic        ddr_busy;
    logic [63:0] ddr_dout;
    logic        ddr_dout_ready;

    modport slave (
        input  ddram_rd, ddram_addr, ddr_busy, ddr_dout, ddr_dout_ready,
        output ddram_dout, ddram_busy, ddram_dout_ready, ddr_rd, ddr_addr, ddr_burstcnt
    );

    modport master (
        output ddram_rd, ddram_addr, ddr_busy, ddr_dout, ddr_dout_ready,
        input  ddram_dout, ddram_busy, ddram_dout_ready, ddr_rd, ddr_addr, ddr_burstcnt
    );
endinterface

// File: rtl/pgm_ddram_reader.sv
// Graphics-ROM read responder: PGM video fetch port onto the DDR3 Avalon-MM read channel.
// Define PGM_DDRAM_CACHE_EN for 4-word line-fill bursts with a one-line buffer; default is single-word reads.
module pgm_ddram_reader #(
    parameter logic [28:0] BASE_ADDR = 29'h0060_0000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    pgm_ddram_reader_if.slave bus,
    output logic              timeout_err
);
    localparam int unsigned   DATA_W   = 64;
    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
`ifdef PGM_DDRAM_CACHE_EN
    localparam logic [2:0]    BEATS    = 3'd4;
`else
    localparam logic [2:0]    BEATS    = 3'd1;
`endif

    typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;

    state_t            state_q, state_d;
    logic              rd_q;
    logic [28:0]       ddr_addr_q, ddr_addr_d;
    logic [1:0]        tgt_q, tgt_d;
    logic [2:0]        beat_q, beat_d;
    logic [2:0]        drain_q, drain_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              err_q, err_d;
    logic              rise;
    logic              beat;

    assign rise = bus.ddram_rd && !rd_q;
    assign beat = bus.ddr_dout_ready;

`ifdef PGM_DDRAM_CACHE_EN
    logic [DATA_W-1:0] line_q [4];
    logic [26:0]       tag_q, tag_d;
    logic              vld_q, vld_d;
    logic              hit;

    assign hit = vld_q && (tag_q == bus.ddram_addr[28:2]);
`endif

    always_comb begin
        state_d    = state_q;
        ddr_addr_d = ddr_addr_q;
        tgt_d      = tgt_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        tmo_d      = tmo_q;
        dout_d     = dout_q;
        err_d      = err_q;
`ifdef PGM_DDRAM_CACHE_EN
        tag_d      = tag_q;
        vld_d      = vld_q;
`endif
        // Late beats of an aborted burst can land in any state except DATA.
        if (drain_q != 3'd0 && beat && state_q != DATA) drain_d = drain_q - 3'd1;

        case (state_q)
            IDLE: begin
                if (rise) begin
`ifdef PGM_DDRAM_CACHE_EN
                    if (hit) begin
                        dout_d  = line_q[bus.ddram_addr[1:0]];
                        state_d = RESP;
                    end else begin
                        ddr_addr_d = BASE_ADDR + {bus.ddram_addr[28:2], 2'b00};
                        tgt_d      = bus.ddram_addr[1:0];
                        tag_d      = bus.ddram_addr[28:2];
                        vld_d      = 1'b0;
                        state_d    = CMD;
                    end
`else
                    ddr_addr_d = BASE_ADDR + bus.ddram_addr;
                    tgt_d      = 2'b00;
                    state_d    = CMD;
`endif
                end
            end
            CMD: begin
                beat_d = '0;
                tmo_d  = '0;
                if (drain_q == 3'd0 && !bus.ddr_busy) state_d = DATA;
            end
            DATA: begin
                if (tmo_q != TMO_LAST) tmo_d = tmo_q + TW'(1);
                // A beat in the timeout cycle takes priority over the abort.
                if (beat) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q[1:0] == tgt_q) dout_d = bus.ddr_dout;
                    if (beat_q == BEATS - 3'd1) begin
                        state_d = RESP;
`ifdef PGM_DDRAM_CACHE_EN
                        vld_d   = 1'b1;
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RESP;
                    dout_d  = '0;
                    err_d   = 1'b1;
                    drain_d = BEATS - beat_q;
`ifdef PGM_DDRAM_CACHE_EN
                    vld_d   = 1'b0;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            ddr_addr_q <= '0;
            tgt_q      <= '0;
            beat_q     <= '0;
            drain_q    <= '0;
            tmo_q      <= '0;
            dout_q     <= '0;
            err_q      <= 1'b0;
`ifdef PGM_DDRAM_CACHE_EN
            vld_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_q       <= bus.ddram_rd;
            ddr_addr_q <= ddr_addr_d;
            tgt_q      <= tgt_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            tmo_q      <= tmo_d;
            dout_q     <= dout_d;
            err_q      <= err_d;
`ifdef PGM_DDRAM_CACHE_EN
            vld_q      <= vld_d;
`endif
        end
    end

`ifdef PGM_DDRAM_CACHE_EN
    // Line contents and tag are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == DATA && beat) line_q[beat_q[1:0]] <= bus.ddr_dout;
        tag_q <= tag_d;
    end
`endif

    assign bus.ddram_dout       = dout_q;
    assign bus.ddram_busy       = (state_q == CMD) || (state_q == DATA);
    assign bus.ddram_dout_ready = (state_q == RESP);
    assign bus.ddr_rd           = (state_q == CMD) && (drain_q == 3'd0);
    assign bus.ddr_addr         = ddr_addr_q;
    assign bus.ddr_burstcnt     = {5'd0, BEATS};
    assign timeout_err          = err_q;
endmodule
